// File: rtl/photon_cnt_sequencer_pkg.sv
// Shared types and constants for the photon-counting acquisition sequencer.
package photon_cnt_sequencer_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StUp    = 3'd2,
        StDown  = 3'd3,
        StCount = 3'd4,
        StDead  = 3'd5
    } state_e;

    // Power-on defaults a host driver can use to program the period registers.
    localparam int unsigned DefCountPeriod  = 1000;
    localparam int unsigned DefLockinPeriod = 500;
    localparam int unsigned DefDeadPeriod   = 0;

endpackage

// File: rtl/photon_cnt_sequencer_period_timer.sv
// Loadable down-counter with zero flag; shared by every window and dead phase.
module photon_cnt_sequencer_period_timer #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Load has priority; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/photon_cnt_sequencer.sv
// Acquisition sequencer: turns a start command and period configuration into
// gate / lock-in phase signals plus window, frame and done strobes.
module photon_cnt_sequencer
    import photon_cnt_sequencer_pkg::*;
#(
    parameter int unsigned COUNTSIZE = 32,
    parameter int unsigned FRAMESIZE = 16
) (
    input  logic                 c_clk,
    input  logic                 c_rst,
    input  logic                 c_start,
    input  logic                 c_abort,
    input  logic                 c_lockin,
    input  logic [COUNTSIZE-1:0] c_lockinup_period,
    input  logic [COUNTSIZE-1:0] c_lockindown_period,
    input  logic [COUNTSIZE-1:0] c_count_period,
    input  logic [COUNTSIZE-1:0] c_dead_period,
    input  logic [FRAMESIZE-1:0] c_num_frames,
    output logic                 c_gate,
    output logic                 c_lockin_inc,
    output logic                 c_window_end,
    output logic                 c_frame_end,
    output logic [FRAMESIZE-1:0] c_frame_idx,
    output logic                 c_busy,
    output logic                 c_done,
    output logic                 c_cfg_err
);

    state_e state_q, state_d, next_win_q, next_win_d, nxt_win;

    logic [COUNTSIZE-1:0] up_q, down_q, count_q, dead_q, nxt_period, timer_val;
    logic                 lockin_q, shadow_load, timer_load, timer_zero, cfg_ok;
    logic                 frame_done, last_frame;
    logic [FRAMESIZE-1:0] num_q, idx_q, idx_d, idx_inc;
    logic gate_q, gate_d, inc_q, inc_d, win_end_q, win_end_d, frame_end_q, frame_end_d;
    logic busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

    photon_cnt_sequencer_period_timer #(
        .Width(COUNTSIZE)
    ) u_timer (
        .clk_i     (c_clk),
        .rst_ni    (c_rst),
        .load_i    (timer_load),
        .load_val_i(timer_val),
        .zero_o    (timer_zero)
    );

    // Only the periods used by the selected mode must be non-zero.
    always_comb begin
        if (c_lockin) begin
            cfg_ok = (c_lockinup_period != '0) && (c_lockindown_period != '0);
        end else begin
            cfg_ok = (c_count_period != '0);
        end
    end

    // Which window follows the current one, and its latched length.
    always_comb begin
        nxt_win = next_win_q;
        if (state_q == StUp) begin
            nxt_win = StDown;
        end else if (state_q != StDead) begin
            nxt_win = lockin_q ? StUp : StCount;
        end
        case (nxt_win)
            StUp:    nxt_period = up_q;
            StDown:  nxt_period = down_q;
            default: nxt_period = count_q;
        endcase
    end

    assign idx_inc    = idx_q + FRAMESIZE'(1);
    assign frame_done = (state_q == StDown) || (state_q == StCount);
    assign last_frame = (num_q != '0) && (idx_inc == num_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        next_win_d  = next_win_q;
        timer_load  = 1'b0;
        timer_val   = nxt_period - COUNTSIZE'(1);
        shadow_load = 1'b0;
        gate_d      = 1'b0;
        inc_d       = inc_q;
        win_end_d   = 1'b0;
        frame_end_d = 1'b0;
        done_d      = 1'b0;
        busy_d      = busy_q;
        cfg_err_d   = cfg_err_q;
        idx_d       = idx_q;
        if (c_abort) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            inc_d   = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    inc_d  = 1'b1;
                    busy_d = 1'b0;
                    if (c_start) begin
                        if (cfg_ok) begin
                            state_d     = StLoad;
                            busy_d      = 1'b1;
                            shadow_load = 1'b1;
                            cfg_err_d   = 1'b0;
                            idx_d       = '0;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                StLoad: begin
                    state_d    = nxt_win;
                    timer_load = 1'b1;
                    gate_d     = 1'b1;
                    inc_d      = 1'b1;
                end
                StUp, StDown, StCount: begin
                    gate_d = 1'b1;
                    if (timer_zero) begin
                        win_end_d = 1'b1;
                        if (frame_done) begin
                            frame_end_d = 1'b1;
                            idx_d       = idx_inc;
                        end
                        if (frame_done && last_frame) begin
                            // Final window: no trailing dead time.
                            state_d = StIdle;
                            gate_d  = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            inc_d   = 1'b1;
                        end else if (dead_q != '0) begin
                            state_d    = StDead;
                            next_win_d = nxt_win;
                            timer_load = 1'b1;
                            timer_val  = dead_q - COUNTSIZE'(1);
                            gate_d     = 1'b0;
                        end else begin
                            state_d    = nxt_win;
                            timer_load = 1'b1;
                            inc_d      = (nxt_win != StDown);
                        end
                    end
                end
                StDead: begin
                    if (timer_zero) begin
                        state_d    = next_win_q;
                        timer_load = 1'b1;
                        gate_d     = 1'b1;
                        inc_d      = (nxt_win != StDown);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge c_clk or negedge c_rst) begin
        if (!c_rst) begin
            state_q     <= StIdle;
            next_win_q  <= StCount;
            gate_q      <= 1'b0;
            inc_q       <= 1'b1;
            win_end_q   <= 1'b0;
            frame_end_q <= 1'b0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_win_q  <= next_win_d;
            gate_q      <= gate_d;
            inc_q       <= inc_d;
            win_end_q   <= win_end_d;
            frame_end_q <= frame_end_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Shadow configuration, captured with the same values that passed the check.
    always_ff @(posedge c_clk or negedge c_rst) begin
        if (!c_rst) begin
            up_q     <= '0;
            down_q   <= '0;
            count_q  <= '0;
            dead_q   <= '0;
            num_q    <= '0;
            lockin_q <= 1'b0;
        end else if (shadow_load) begin
            up_q     <= c_lockinup_period;
            down_q   <= c_lockindown_period;
            count_q  <= c_count_period;
            dead_q   <= c_dead_period;
            num_q    <= c_num_frames;
            lockin_q <= c_lockin;
        end
    end

    assign c_gate       = gate_q;
    assign c_lockin_inc = inc_q;
    assign c_window_end = win_end_q;
    assign c_frame_end  = frame_end_q;
    assign c_frame_idx  = idx_q;
    assign c_busy       = busy_q;
    assign c_done       = done_q;
    assign c_cfg_err    = cfg_err_q;

endmodule
